// File: rtl/niossoc_key_pio.sv
// niossoc_key_pio: Avalon-MM input PIO for push buttons and switches.
// Each input bit is synchronized, optionally debounced, and edge-captured.
// A maskable level interrupt is raised to the Nios II core.
//
// Build option: define KEY_PIO_DEBOUNCE_EN to include a per-bit stable-count
// debouncer in front of the level stage. When it is undefined, the level
// is the synchronizer output directly.
//
// Register map (zero-wait-state reads; readdata is not gated by chipselect):
//   0 data        RO   {0, lvl}
//   1 reserved    RO   0
//   2 irqmask     RW   WIDTH bits
//   3 edgecapture W1C  WIDTH bits; a set wins over a clear in the same cycle

`timescale 1ns/1ps

module niossoc_key_pio #(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    // Terminal count for the debounce counter: the level flips on the cycle
    // the counter has seen DEBOUNCE_CYCLES consecutive differing samples.
    localparam logic [15:0] DEB_MAX = 16'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAP  = 2'd3;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;

    logic [WIDTH-1:0] w_lvl;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic             w_mask_we;
    logic             w_unused;

    // Two-flop synchronizer; resets to ones because idle keys read high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

`ifdef KEY_PIO_DEBOUNCE_EN
    logic [WIDTH-1:0] r_lvl;
    logic [15:0]      r_cnt [WIDTH];

    // Per-bit debouncer: the level follows the synchronized input only after
    // it has differed for DEBOUNCE_CYCLES consecutive cycles; any agreement
    // restarts the count, so short glitches never reach the level stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lvl <= '1;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] != r_lvl[i]) begin
                    if (r_cnt[i] == DEB_MAX) begin
                        r_lvl[i] <= r_sync2[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 16'd1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_lvl = r_lvl;
`else
    assign w_lvl = r_sync2;
`endif

    // Previous level, used to detect transitions one cycle at a time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= '1;
        end else begin
            r_prev <= w_lvl;
        end
    end

    assign w_rise = w_lvl & ~r_prev;
    assign w_fall = ~w_lvl & r_prev;

    // Choose which transitions are captured; unknown settings fall back to falling.
    always_comb begin
        w_edge = w_fall;
        case (EDGE_TYPE)
            0:       w_edge = w_rise;
            2:       w_edge = w_rise | w_fall;
            default: w_edge = w_fall;
        endcase
    end

    assign w_wr      = chipselect & ~write_n;
    assign w_mask_we = w_wr && (address == ADDR_MASK);
    assign w_clr     = (w_wr && (address == ADDR_CAP)) ? writedata[WIDTH-1:0] : '0;

    // Interrupt mask register, written directly from the bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irqmask <= '0;
        end else if (w_mask_we) begin
            r_irqmask <= writedata[WIDTH-1:0];
        end
    end

    // Sticky edge capture; the OR after the clear lets a new edge win a collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edgecap <= '0;
        end else begin
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
        end
    end

    assign irq = |(r_edgecap & r_irqmask);

    // Zero-latency read mux; unused upper bits and the reserved slot read zero.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = w_lvl;
            ADDR_MASK: readdata[WIDTH-1:0] = r_irqmask;
            ADDR_CAP:  readdata[WIDTH-1:0] = r_edgecap;
            default:   readdata = '0;
        endcase
    end

    // Write-data bits above WIDTH and the debounce terminal count (in builds
    // without the debouncer) are intentionally not consumed.
    assign w_unused = ^{writedata, DEB_MAX};

endmodule

// File: tb/tb_niossoc_key_pio.sv
// tb_niossoc_key_pio: directed scoreboard bench for niossoc_key_pio.
// Stimulus pushes the expected read value and irq level into a queue; a
// monitor pops and compares on every bus read cycle.

`timescale 1ns/1ps

module tb_niossoc_key_pio;

`ifdef KEY_PIO_DEBOUNCE_EN
    localparam int LAT = 2 + 4;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;

    typedef struct {
        logic [31:0] data;
        logic        irqLvl;
        string       name;
    } expT;

    expT sbQ[$];
    expT cur;
    int  errors = 0;
    int  checks = 0;

    niossoc_key_pio #(
        .WIDTH(4),
        .EDGE_TYPE(1),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish, required finish before 1 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: every bus read cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        if (chipselect && write_n) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_read: got read at addr %0d, required none", address);
            end else begin
                cur = sbQ.pop_front();
                checks++;
                if (readdata !== cur.data) begin
                    errors++;
                    $display("[TB] FAIL %s readdata: got 0x%08h, required 0x%08h", cur.name, readdata, cur.data);
                end
                checks++;
                if (irq !== cur.irqLvl) begin
                    errors++;
                    $display("[TB] FAIL %s irq: got %0b, required %0b", cur.name, irq, cur.irqLvl);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle: write when isWrite, otherwise leave the bus idle.
    task automatic applyStimulus(input bit isWrite, input logic [1:0] a, input logic [31:0] d);
        chipselect = isWrite;
        write_n    = ~isWrite;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 2'd0, 32'h0);
        end
    endtask

    // One read cycle with its expected readdata and irq queued for the monitor.
    task automatic checkOutput(input logic [1:0] a, input logic [31:0] expData,
                               input logic expIrq, input string name);
        expT e;
        e.data   = expData;
        e.irqLvl = expIrq;
        e.name   = name;
        sbQ.push_back(e);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        tick();
        chipselect = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        tick();
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Reset values of every register.
        checkOutput(2'd0, 32'hF, 1'b0, "rst_data");
        checkOutput(2'd1, 32'h0, 1'b0, "rst_reserved");
        checkOutput(2'd2, 32'h0, 1'b0, "rst_mask");
        checkOutput(2'd3, 32'h0, 1'b0, "rst_cap");

        // Writes to data and reserved are ignored.
        applyStimulus(1'b1, 2'd0, 32'h0);
        applyStimulus(1'b1, 2'd1, 32'hFFFF_FFFF);
        checkOutput(2'd0, 32'hF, 1'b0, "ro_data");
        checkOutput(2'd1, 32'h0, 1'b0, "ro_reserved");

        // Bit 0 falls with mask bit 0 set: level after LAT, capture one later.
        applyStimulus(1'b1, 2'd2, 32'h1);
        in_port = 4'hE;
        idleCycles(LAT - 1);
        checkOutput(2'd0, 32'hF, 1'b0, "lvl_before");
        checkOutput(2'd0, 32'hE, 1'b0, "lvl_after");
        checkOutput(2'd3, 32'h1, 1'b1, "cap_bit0");

        // Clear bit 0, then capture bit 1 while it is masked off.
        applyStimulus(1'b1, 2'd3, 32'h1);
        checkOutput(2'd3, 32'h0, 1'b0, "clr_bit0");
        in_port = 4'hC;
        idleCycles(LAT + 1);
        checkOutput(2'd3, 32'h2, 1'b0, "cap_bit1_masked");
        applyStimulus(1'b1, 2'd2, 32'h3);
        checkOutput(2'd3, 32'h2, 1'b1, "cap_bit1_unmasked");
        checkOutput(2'd2, 32'h3, 1'b1, "mask_rd");

        // Clear of bit 2 lands on the same edge that captures bit 2: set wins.
        in_port = 4'h8;
        idleCycles(LAT);
        applyStimulus(1'b1, 2'd3, 32'h4);
        checkOutput(2'd3, 32'h6, 1'b1, "collision");
        applyStimulus(1'b1, 2'd3, 32'h4);
        checkOutput(2'd3, 32'h2, 1'b1, "clr_bit2");
        checkOutput(2'd0, 32'h8, 1'b1, "lvl_8");

        // Rising edges are not captured with falling-edge selection.
        in_port = 4'hF;
        idleCycles(LAT + 2);
        checkOutput(2'd0, 32'hF, 1'b1, "lvl_release");
        checkOutput(2'd3, 32'h2, 1'b1, "no_rise_cap");
        applyStimulus(1'b1, 2'd3, 32'hF);
        checkOutput(2'd3, 32'h0, 1'b0, "clr_all");

`ifdef KEY_PIO_DEBOUNCE_EN
        // A 3-cycle glitch on bit 3 is filtered out.
        in_port = 4'h7;
        idleCycles(3);
        in_port = 4'hF;
        idleCycles(8);
        checkOutput(2'd0, 32'hF, 1'b0, "glitch_lvl");
        checkOutput(2'd3, 32'h0, 1'b0, "glitch_cap");

        // A long press on bit 3 passes after 2 sync + 4 stable cycles.
        applyStimulus(1'b1, 2'd2, 32'hF);
        in_port = 4'h7;
        idleCycles(5);
        checkOutput(2'd0, 32'hF, 1'b0, "deb_before");
        checkOutput(2'd0, 32'h7, 1'b0, "deb_after");
        checkOutput(2'd3, 32'h8, 1'b1, "deb_cap");
        in_port = 4'hF;
        idleCycles(LAT + 2);
        checkOutput(2'd0, 32'hF, 1'b1, "deb_release");
        applyStimulus(1'b1, 2'd3, 32'hF);
        checkOutput(2'd3, 32'h0, 1'b0, "deb_clr");
`endif

        // Reset in the middle of activity with every bit captured and enabled.
        applyStimulus(1'b1, 2'd2, 32'hF);
        in_port = 4'h0;
        idleCycles(LAT + 1);
        checkOutput(2'd3, 32'hF, 1'b1, "cap_all");
        reset_n = 1'b0;
        in_port = 4'hF;
        checkOutput(2'd3, 32'h0, 1'b0, "in_rst_cap");
        checkOutput(2'd2, 32'h0, 1'b0, "in_rst_mask");
        reset_n = 1'b1;
        idleCycles(LAT + 2);
        checkOutput(2'd0, 32'hF, 1'b0, "post_rst_data");
        checkOutput(2'd1, 32'h0, 1'b0, "post_rst_reserved");
        checkOutput(2'd2, 32'h0, 1'b0, "post_rst_mask");
        checkOutput(2'd3, 32'h0, 1'b0, "post_rst_cap");

        idleCycles(2);
        if (sbQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", sbQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
